// File: rtl/pcpi_initiator_if.sv
// Issue-side, coprocessor-side and response-side signals of the PCPI initiator.
// master = initiator, slave = issuing stage, coprocessor and consumer.
interface pcpi_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic        rsp_timeout;
  logic        err_spurious;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2,
    input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy,
    input  rsp_ready,
    output req_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output rsp_valid, rsp_data, rsp_wr, rsp_timeout,
    output err_spurious
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2,
    output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy,
    output rsp_ready,
    input  req_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  rsp_valid, rsp_data, rsp_wr, rsp_timeout,
    input  err_spurious
  );
endinterface

// File: rtl/pcpi_initiator.sv
// Single-outstanding PCPI request issuer with busy-aware timeout
// and a held completion record.
module pcpi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             resetn,
  pcpi_initiator_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        wr;
    logic        timeout;
  } rsp_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d;
  rsp_t          rsp_q, rsp_d;
  logic          spur_q, spur_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      spur_q  <= spur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    // a completion strobe outside ISSUE has no target
    spur_d  = spur_q | (bus.pcpi_ready & (state_q != ISSUE));
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d   = '{insn: bus.req_insn,
                      rs1:  bus.req_rs1,
                      rs2:  bus.req_rs2};
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.pcpi_ready) begin
          rsp_d   = '{data:    bus.pcpi_rd,
                      wr:      bus.pcpi_wr,
                      timeout: 1'b0};
          state_d = RESP;
        end else if (bus.pcpi_busy) begin
          cnt_d = '0;
        end else if (cnt_inc == TO_LIM) begin
          rsp_d   = '{data: '0, wr: 1'b0, timeout: 1'b1};
          cnt_d   = cnt_inc;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.pcpi_valid   = (state_q == ISSUE);
  assign bus.pcpi_insn    = req_q.insn;
  assign bus.pcpi_rs1     = req_q.rs1;
  assign bus.pcpi_rs2     = req_q.rs2;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_data     = rsp_q.data;
  assign bus.rsp_wr       = rsp_q.wr;
  assign bus.rsp_timeout  = rsp_q.timeout;
  assign bus.err_spurious = spur_q;

endmodule
